// File: rtl/core_wb_pkg.sv
// Shared writeback definitions: request record, WB mux source selects and
// the arbitration-winner encoding.
package core_wb_pkg;

  localparam int unsigned WB_XLEN    = 32;
  localparam int unsigned WB_RADDR_W = 5;

  typedef struct packed {
    logic [WB_RADDR_W-1:0] rd;
    logic [WB_XLEN-1:0]    data;
  } wb_req_t;

  localparam logic [2:0] WB_SRC_ALU  = 3'd0;
  localparam logic [2:0] WB_SRC_DMEM = 3'd1;
  localparam logic [2:0] WB_SRC_PC4  = 3'd2;
  localparam logic [2:0] WB_SRC_IMM  = 3'd3;
  localparam logic [2:0] WB_SRC_CSR  = 3'd4;
  localparam logic [2:0] WB_SRC_MUL  = 3'd5;

  typedef enum logic [1:0] {
    WIN_NONE,
    WIN_PIPE,
    WIN_QUEUE,
    WIN_BYPASS
  } wb_win_e;

endpackage

// File: rtl/core_wb_fifo.sv
// Synchronous FIFO with show-ahead head output. The caller guarantees no push
// when full unless it pops in the same cycle, and no pop when empty.
module core_wb_fifo
  import core_wb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wb_req_t
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_push,
  input  T     i_data,
  input  logic i_pop,
  output T     o_data,
  output logic o_full,
  output logic o_empty
);

  localparam int AW = $clog2(DEPTH);

  T               mem_q [DEPTH];
  logic [AW:0]    wr_ptr_q, rd_ptr_q;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (i_push) wr_ptr_q <= wr_ptr_q + {{AW{1'b0}}, 1'b1};
      if (i_pop)  rd_ptr_q <= rd_ptr_q + {{AW{1'b0}}, 1'b1};
    end
  end

  // Push into a full FIFO lands in the slot being popped; the old head is
  // still read combinationally this cycle.
  always_ff @(posedge i_clk) begin
    if (i_push) mem_q[wr_ptr_q[AW-1:0]] <= i_data;
  end

  assign o_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign o_empty = (wr_ptr_q == rd_ptr_q);
  assign o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

endmodule

// File: rtl/core_wb_arbiter.sv
// Register-file write-port owner: arbitrates pipeline writeback against
// buffered or bypassed multiplier results and tracks outstanding mul rds.
module core_wb_arbiter
  import core_wb_pkg::*;
#(
  parameter int XLEN         = WB_XLEN,
  parameter int RADDR_W      = WB_RADDR_W,
  parameter int MUL_QDEPTH   = 2,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_pipe_we,
  input  logic [RADDR_W-1:0]    i_pipe_rd_addr,
  input  logic [XLEN-1:0]       i_pipe_rd_din,
  output logic                  o_pipe_stall,
  input  logic                  i_mul_issue,
  input  logic [RADDR_W-1:0]    i_mul_issue_rd,
  input  logic                  i_mul_valid,
  input  logic [RADDR_W-1:0]    i_mul_rd_addr,
  input  logic [XLEN-1:0]       i_mul_result,
  output logic                  o_mul_ready,
  output logic                  o_rf_we,
  output logic [RADDR_W-1:0]    o_rf_waddr,
  output logic [XLEN-1:0]       o_rf_wdata,
  output logic [2**RADDR_W-1:0] o_busy_mask
);

  localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(STARVE_LIMIT);

  logic [AGE_W-1:0]       age_q, age_d;
  logic [2**RADDR_W-1:0]  busy_q, busy_d;

  wb_win_e  win;
  wb_req_t  head, push_req;
  logic     q_full, q_empty, head_req;
  logic     pipe_req, waw, age_inc, pop, push, bypass;
  logic     clr_valid;
  logic [RADDR_W-1:0] clr_rd;

  assign pipe_req = i_pipe_we && (i_pipe_rd_addr != '0);
  assign waw      = pipe_req && busy_q[i_pipe_rd_addr];
  assign head_req = !q_empty;

  always_comb begin
    win          = WIN_NONE;
    o_pipe_stall = 1'b0;
    age_inc      = 1'b0;
    if (head_req && (q_full || (age_q == AGE_MAX) || waw)) begin
      win          = WIN_QUEUE;
      o_pipe_stall = pipe_req;
    end else if (pipe_req && !waw) begin
      win     = WIN_PIPE;
      age_inc = head_req;
    end else if (head_req) begin
      win          = WIN_QUEUE;
      o_pipe_stall = waw;
    end else if (i_mul_valid) begin
      // FIFO is empty here; a WAW-blocked pipe must keep holding.
      win          = WIN_BYPASS;
      o_pipe_stall = waw;
    end else begin
      o_pipe_stall = waw;
    end
    if (i_rst) begin
      win          = WIN_NONE;
      o_pipe_stall = 1'b0;
      age_inc      = 1'b0;
    end
  end

  assign pop         = (win == WIN_QUEUE);
  assign bypass      = (win == WIN_BYPASS);
  assign o_mul_ready = !i_rst && (!q_full || pop);
  assign push        = i_mul_valid && o_mul_ready && !bypass;
  assign push_req    = '{rd: i_mul_rd_addr, data: i_mul_result};

  core_wb_fifo #(.DEPTH(MUL_QDEPTH), .T(wb_req_t)) u_fifo (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_push (push),
    .i_data (push_req),
    .i_pop  (pop),
    .o_data (head),
    .o_full (q_full),
    .o_empty(q_empty)
  );

  always_comb begin
    o_rf_we    = 1'b0;
    o_rf_waddr = '0;
    o_rf_wdata = '0;
    clr_valid  = 1'b0;
    clr_rd     = '0;
    unique case (win)
      WIN_PIPE: begin
        o_rf_we    = 1'b1;
        o_rf_waddr = i_pipe_rd_addr;
        o_rf_wdata = i_pipe_rd_din;
      end
      WIN_QUEUE: begin
        o_rf_we    = (head.rd != '0);
        o_rf_waddr = head.rd;
        o_rf_wdata = head.data;
        clr_valid  = 1'b1;
        clr_rd     = head.rd;
      end
      WIN_BYPASS: begin
        o_rf_we    = (i_mul_rd_addr != '0);
        o_rf_waddr = i_mul_rd_addr;
        o_rf_wdata = i_mul_result;
        clr_valid  = 1'b1;
        clr_rd     = i_mul_rd_addr;
      end
      default: ;
    endcase
  end

  // Set after clear so a same-cycle issue to the retiring rd stays busy.
  always_comb begin
    busy_d = busy_q;
    if (clr_valid)   busy_d[clr_rd]         = 1'b0;
    if (i_mul_issue) busy_d[i_mul_issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_comb begin
    age_d = age_q;
    if (pop)                            age_d = '0;
    else if (age_inc && age_q != AGE_MAX) age_d = age_q + {{(AGE_W-1){1'b0}}, 1'b1};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      age_q  <= '0;
      busy_q <= '0;
    end else begin
      age_q  <= age_d;
      busy_q <= busy_d;
    end
  end

  assign o_busy_mask = busy_q;

endmodule
